// File: rtl/skywater_dlyline_code_ctrl_if.sv
// Request/status bundle between the DLL/calibration logic and the delay-line code controller.
// The master drives the requests and the slave returns the thermometer word and status.
interface skywater_dlyline_code_ctrl_if #(
  parameter int NCELL = 64,
  parameter int CW    = 7
);
  logic [CW-1:0]    code_in;
  logic             code_ld;
  logic             immed;
  logic             inc;
  logic             dec;
  logic [NCELL-1:0] bk;
  logic [CW-1:0]    code_cur;
  logic             busy;
  logic             done;
  logic             sat;

  modport master (
    output code_in, code_ld, immed, inc, dec,
    input  bk, code_cur, busy, done, sat
  );

  modport slave (
    input  code_in, code_ld, immed, inc, dec,
    output bk, code_cur, busy, done, sat
  );
endinterface

// File: rtl/skywater_dlyline_code_ctrl.sv
// Converts a binary delay target into the thermometer bk word for the delay line.
// It supports ramped one-cell stepping, immediate jumps, DLL inc/dec requests and clamping.
module skywater_dlyline_code_ctrl #(
  parameter int NCELL    = 64,
  parameter int CW       = 7,
  parameter int DIV      = 4,
  parameter int RST_CODE = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  skywater_dlyline_code_ctrl_if.slave       bus
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] MAXC  = CW'(NCELL - 1);
  localparam logic [CW-1:0] RSTC  = CW'(RST_CODE);
  localparam logic [DW-1:0] RELOAD = DW'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STEP} state_t;

  function automatic logic [NCELL-1:0] therm(input logic [CW-1:0] c);
    logic [NCELL-1:0] t;
    for (int i = 0; i < NCELL; i++) t[i] = (i < int'(c));
    return t;
  endfunction

  function automatic logic over_range(input logic [CW-1:0] c);
    return int'(c) > NCELL - 1;
  endfunction

  function automatic logic [CW-1:0] clamp_code(input logic [CW-1:0] c);
    return over_range(c) ? MAXC : c;
  endfunction

  state_t           state_q, state_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    code_q, code_d;
  logic [CW-1:0]    tgt_q, tgt_d;
  logic [NCELL-1:0] bk_q, bk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sat_q, sat_d;

  logic [CW-1:0]    ld_tgt;
  logic [CW-1:0]    goal;
  logic [CW-1:0]    stepped;
  logic             run;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    tgt_d   = tgt_q;
    busy_d  = busy_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    run     = 1'b0;
    goal    = tgt_q;
    stepped = code_q;
    ld_tgt  = clamp_code(bus.code_in);

    if (bus.code_ld) begin
      sat_d = over_range(bus.code_in);
      if (bus.immed) begin
        code_d  = ld_tgt;
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = '0;
      end else if (ld_tgt == code_q) begin
        // Covers both an idle no-move load and a retarget onto the current code.
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = '0;
        tgt_d   = ld_tgt;
      end else if (state_q == S_IDLE) begin
        tgt_d   = ld_tgt;
        state_d = (DIV == 1) ? S_STEP : S_WAIT;
        cnt_d   = RELOAD;
        busy_d  = 1'b1;
      end else begin
        // Retarget keeps the divider phase running toward the new goal.
        tgt_d = ld_tgt;
        goal  = ld_tgt;
        run   = 1'b1;
      end
    end else if (state_q == S_IDLE) begin
      if (bus.inc ^ bus.dec) begin
        done_d = 1'b1;
        if ((bus.inc && code_q == MAXC) || (bus.dec && code_q == '0)) begin
          sat_d = 1'b1;
        end else begin
          sat_d  = 1'b0;
          code_d = bus.inc ? code_q + CW'(1) : code_q - CW'(1);
        end
      end
    end else begin
      run = 1'b1;
    end

    if (run) begin
      case (state_q)
        S_WAIT: begin
          cnt_d = cnt_q - DW'(1);
          if (cnt_q == DW'(1)) state_d = S_STEP;
        end
        S_STEP: begin
          stepped = (goal > code_q) ? code_q + CW'(1) : code_q - CW'(1);
          code_d  = stepped;
          if (stepped == goal) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = (DIV == 1) ? S_STEP : S_WAIT;
            cnt_d   = RELOAD;
          end
        end
        default: ;
      endcase
    end

    bk_d = therm(code_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      code_q  <= RSTC;
      tgt_q   <= RSTC;
      bk_q    <= therm(RSTC);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      tgt_q   <= tgt_d;
      bk_q    <= bk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.bk       = bk_q;
  assign bus.code_cur = code_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sat      = sat_q;

endmodule

// File: tb/tb_skywater_dlyline_code_ctrl.sv
// Bench for skywater_dlyline_code_ctrl: constant vector table, hand-written ramp/retarget/reset
// sequences, and randomized traffic against an event-time reference model.
module tb_skywater_dlyline_code_ctrl;
  localparam int NCELL = 64;
  localparam int CW = 7;
  localparam int DIV = 4;
  localparam int RST_CODE = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  skywater_dlyline_code_ctrl_if #(.NCELL(NCELL), .CW(CW)) bus ();

  skywater_dlyline_code_ctrl #(.NCELL(NCELL), .CW(CW), .DIV(DIV), .RST_CODE(RST_CODE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail = 0;

  // reference model: ramp cadence tracked as the absolute edge number of the next step
  int cyc = 0;
  int m_code, m_tgt, m_next;
  bit m_busy, m_done, m_sat;

  function automatic logic [63:0] therm_ref(input int c);
    return (64'd1 << c) - 64'd1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step_if_due();
    if (cyc == m_next) begin
      m_code += (m_tgt > m_code) ? 1 : -1;
      if (m_code == m_tgt) begin m_busy = 0; m_done = 1; end
      else m_next = cyc + DIV;
    end
  endtask

  task automatic model_edge();
    int t;
    bit r, ld, im, in_, de;
    r = rst; ld = bus.code_ld; im = bus.immed; in_ = bus.inc; de = bus.dec;
    m_done = 0;
    if (r) begin
      m_code = RST_CODE; m_tgt = RST_CODE; m_busy = 0; m_sat = 0;
    end else if (ld) begin
      t = (int'(bus.code_in) > NCELL - 1) ? NCELL - 1 : int'(bus.code_in);
      m_sat = int'(bus.code_in) > NCELL - 1;
      if (im) begin
        m_code = t; m_busy = 0; m_done = 1;
      end else if (t == m_code) begin
        m_busy = 0; m_done = 1; m_tgt = t;
      end else if (!m_busy) begin
        m_tgt = t; m_busy = 1; m_next = cyc + DIV;
      end else begin
        m_tgt = t;
        model_step_if_due();
      end
    end else if (!m_busy) begin
      if (in_ != de) begin
        m_done = 1;
        if ((in_ && m_code == NCELL - 1) || (de && m_code == 0)) m_sat = 1;
        else begin m_code += in_ ? 1 : -1; m_sat = 0; end
      end
    end else begin
      model_step_if_due();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("model.code_cur", 64'(bus.code_cur), 64'(m_code));
    chk("model.bk", bus.bk, therm_ref(m_code));
    chk("model.busy", 64'(bus.busy), 64'(m_busy));
    chk("model.done", 64'(bus.done), 64'(m_done));
    chk("model.sat", 64'(bus.sat), 64'(m_sat));
  endtask

  task automatic idle_inputs();
    bus.code_ld = 0; bus.immed = 0; bus.inc = 0; bus.dec = 0; bus.code_in = '0; rst = 0;
  endtask

  task automatic load(input int c, input bit im);
    bus.code_ld = 1; bus.code_in = CW'(c); bus.immed = im;
    tick();
    idle_inputs();
  endtask

  task automatic wait_code(input int c, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (int'(bus.code_cur) == c) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL wait_code: code_cur %0d never reached %0d", bus.code_cur, c);
    end
  endtask

  typedef struct {
    bit rst, ld, im, inc, dec;
    int cin;
    int code;
    bit busy, done, sat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int prev_code, steps, dones, toggles, nchg;
    int seen[$];
    logic [63:0] prev_bk;

    //          rst ld im inc dec cin code busy done sat
    vecs.push_back('{1, 0, 0, 0, 0,   0,  0, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0,   0,  0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0,   0,  0, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 0, 0,  40, 40, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 0,   0, 40, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 0, 0, 100, 63, 0, 1, 1});
    vecs.push_back('{0, 0, 0, 1, 0,   0, 63, 0, 1, 1});
    vecs.push_back('{0, 0, 0, 0, 0,   0, 63, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 1, 1,   0, 63, 0, 0, 1});
    vecs.push_back('{0, 1, 1, 0, 0,   0,  0, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 1,   0,  0, 0, 1, 1});
    vecs.push_back('{0, 0, 0, 1, 1,   0,  0, 0, 0, 1});
    vecs.push_back('{0, 1, 1, 0, 0,  10, 10, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 1,   0,  9, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 1, 0,   0, 10, 0, 1, 0});
    vecs.push_back('{0, 1, 0, 0, 0,  10, 10, 0, 1, 0});
    vecs.push_back('{0, 1, 1, 0, 0,   0,  0, 0, 1, 0});
    vecs.push_back('{0, 1, 0, 0, 0,   0,  0, 0, 1, 0});

    idle_inputs();
    rst = 1;
    m_code = RST_CODE; m_tgt = RST_CODE; m_busy = 0; m_sat = 0; m_done = 0; m_next = -1;

    foreach (vecs[i]) begin
      rst = vecs[i].rst; bus.code_ld = vecs[i].ld; bus.immed = vecs[i].im;
      bus.inc = vecs[i].inc; bus.dec = vecs[i].dec; bus.code_in = CW'(vecs[i].cin);
      tick();
      chk($sformatf("vec%0d.code_cur", i), 64'(bus.code_cur), 64'(vecs[i].code));
      chk($sformatf("vec%0d.bk", i), bus.bk, therm_ref(vecs[i].code));
      chk($sformatf("vec%0d.busy", i), 64'(bus.busy), 64'(vecs[i].busy));
      chk($sformatf("vec%0d.done", i), 64'(bus.done), 64'(vecs[i].done));
      chk($sformatf("vec%0d.sat", i), 64'(bus.sat), 64'(vecs[i].sat));
    end
    idle_inputs();
    tick();

    // ramp 0 -> 5: one step every DIV edges, one bk bit per edge
    load(5, 0);
    chk("ramp.busy_after_load", 64'(bus.busy), 64'd1);
    steps = 0; toggles = 0; dones = 0; prev_bk = bus.bk;
    for (int k = 1; k <= 5 * DIV; k++) begin
      tick();
      nchg = $countones(bus.bk ^ prev_bk);
      if (nchg > 1) toggles++;
      if (nchg == 1) steps++;
      if (bus.done) dones++;
      prev_bk = bus.bk;
      chk($sformatf("ramp.code_k%0d", k), 64'(bus.code_cur), 64'(k / DIV));
    end
    chk("ramp.final_bk", bus.bk, 64'h1F);
    chk("ramp.final_done", 64'(bus.done), 64'd1);
    chk("ramp.final_busy", 64'(bus.busy), 64'd0);
    chk("ramp.step_count", 64'(steps), 64'd5);
    chk("ramp.multi_bit_edges", 64'(toggles), 64'd0);
    chk("ramp.done_pulses", 64'(dones), 64'd1);
    tick();
    chk("ramp.done_cleared", 64'(bus.done), 64'd0);

    // retarget downward mid-ramp
    load(0, 1);
    load(10, 0);
    wait_code(3, 100, ok);
    load(1, 0);
    chk("retarget.still_busy", 64'(bus.busy), 64'd1);
    prev_code = int'(bus.code_cur); dones = 0; seen.delete();
    for (int k = 0; k < 4 * DIV && !(dones > 0 && !bus.busy && k > 2 * DIV); k++) begin
      tick();
      if (int'(bus.code_cur) != prev_code) seen.push_back(int'(bus.code_cur));
      prev_code = int'(bus.code_cur);
      if (bus.done) dones++;
    end
    chk("retarget.n_steps", 64'(seen.size()), 64'd2);
    if (seen.size() == 2) begin
      chk("retarget.first", 64'(seen[0]), 64'd2);
      chk("retarget.second", 64'(seen[1]), 64'd1);
    end
    chk("retarget.done_pulses", 64'(dones), 64'd1);
    chk("retarget.final_busy", 64'(bus.busy), 64'd0);

    // reset in the middle of a ramp
    load(0, 1);
    load(10, 0);
    wait_code(6, 100, ok);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_mid.code_cur", 64'(bus.code_cur), 64'(RST_CODE));
    chk("rst_mid.bk", bus.bk, 64'd0);
    chk("rst_mid.busy", 64'(bus.busy), 64'd0);
    chk("rst_mid.done", 64'(bus.done), 64'd0);
    chk("rst_mid.sat", 64'(bus.sat), 64'd0);
    tick();

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.code_ld = ($urandom_range(0, 9) == 0);
      bus.code_in = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(60, 127))
                                                 : CW'($urandom_range(0, 63));
      bus.immed = ($urandom_range(0, 2) == 0);
      bus.inc = ($urandom_range(0, 3) == 0);
      bus.dec = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/skywater_dlyline_code_ctrl.md
# skywater_dlyline_code_ctrl

Parametrised code controller for the SkyWater thermometer-coded delay line. It converts a binary delay target into the per-cell `bk` thermometer word. The delay line's cell count (`NCELL`) is generic rather than fixed at 64. Beyond a plain decoder, it adds glitch-safe ramped stepping (one cell per `DIV` cycles), an immediate-jump mode, single-step inc/dec requests from a DLL phase detector, and target clamping with a saturation flag. It sits between the DLL/calibration logic and the delay-line `bk[NCELL-1:0]` inputs.

## Interface
Parameters:
- `NCELL`, 64, number of delay cells; legal codes are 0..NCELL-1.
- `CW`, 7, code width; must satisfy 2^CW > NCELL-1.
- `DIV`, 4, cycles between ramp steps; must be ≥1.
- `RST_CODE`, 0, code loaded at reset; must be in 0..NCELL-1.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `code_in`  in  CW  target delay code; sampled when `code_ld`=1.
- `code_ld`  in  1  one-cycle load request.
- `immed`  in  1  mode bit, sampled with `code_ld`: 1 = jump directly, 0 = ramp.
- `inc`  in  1  single-step up request.
- `dec`  in  1  single-step down request.
- `bk`  out  NCELL  thermometer: `bk[i]` = (i < `code_cur`); registered.
- `code_cur`  out  CW  current applied code; registered, always consistent with `bk`.
- `busy`  out  1  high while a ramp is in progress.
- `done`  out  1  one-cycle pulse when a request completes.
- `sat`  out  1  high if the last accepted request was clamped or saturated.

## Operation
- **States:** IDLE, WAIT, STEP.
  - WAIT: the divider counts down from DIV-1.
  - STEP: the one-cycle code update, merged with the counter reload.
- **Clamping:** a `code_in` value greater than NCELL-1 is clamped to NCELL-1, and `sat` is set to 1. Any accepted non-clamped request clears `sat` to 0.
- **Load, immed=1:** `code_cur` and `bk` take the target at the next edge. `done` pulses in that same cycle. `busy` stays 0.
- **Load, immed=0, target == `code_cur`:** `done` pulses next cycle. State stays IDLE. `busy` stays 0.
- **Load, immed=0, target ≠ `code_cur`:** the target is latched and the state goes to WAIT with `busy`=1.
  - Each time the counter expires, `code_cur` moves by ±1 toward the target and the counter reloads.
  - On reaching the target: return to IDLE, `busy`=0, and `done` pulses.
- **inc/dec (IDLE only):** treated as an immediate load of `code_cur`±1.
  - `inc` at NCELL-1 or `dec` at 0: no code change, `sat`=1, `done` pulses.
  - `inc` and `dec` asserted together: no-op, with no `done` and no `sat` change.
- **Priority:** `code_ld` takes priority over `inc`/`dec`. `inc`/`dec` are ignored while `busy`=1.
- **Retarget:** `code_ld` with immed=0 while `busy`=1 replaces the target. Direction may reverse. The divider is not restarted.
- **Retarget to current code:** if a retarget equals `code_cur`, the ramp ends next cycle with a `done` pulse.
- **Immediate load while busy:** `code_ld` with immed=1 while `busy`=1 aborts the ramp, jumps to the target, and pulses `done`.
- **Arithmetic:** the code never wraps. Ramp steps are strictly ±1 and stay within 0..NCELL-1.
- **`bk` update rule:** `bk` changes in at most one bit per edge during a ramp. Multiple bits may change only on an immediate load.

## Timing
- **Reset values (the edge with `rst`=1):**
  - `code_cur`=RST_CODE, `bk`=thermometer(RST_CODE).
  - `busy`=0, `done`=0, `sat`=0, state=IDLE, divider=0.
- **Reset mid-ramp:** abandons the ramp. All outputs take their reset values at that edge.
- **Ramp latency:** load sampled at edge E0.
  - Step k (k=1..|Δ|) is applied at edge E0+k·DIV.
  - `done`=1 for the cycle after edge E0+|Δ|·DIV.
  - `busy`=1 from E0+1 through the final step edge.
- **Immediate/inc/dec latency:** 1 cycle. `done` is high in the cycle after the sampling edge.
- **Output registration:** all outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** NCELL=64, RST_CODE=0, assert `rst` for 2 cycles → `bk`=0, `code_cur`=0, `busy`=`done`=`sat`=0.
- **Ramp:** DIV=4, from 0, `code_ld` with `code_in`=5, immed=0 → `code_cur` = 1,2,3,4,5 at edges +4,+8,+12,+16,+20; `bk`=0x1F; a single `done` pulse after +20; exactly one `bk` bit toggles per step.
- **Immediate + clamp:**
  - `code_in`=40 with immed=1 → `bk`=2^40−1 after 1 cycle, `done` pulse, `busy` never set.
  - Then `code_in`=100 → `code_cur`=63, `bk` all ones, `sat`=1.
- **inc/dec saturation:**
  - At 63, `inc` → `sat`=1, `done` pulse, `code_cur` stays 63.
  - At 0, `dec` → same behaviour.
  - `inc`&`dec` together → nothing changes, no `done`.
  - At 10, `dec` → 9 and `sat`=0.
- **Retarget and reset:**
  - Ramp 0→10; when `code_cur`=3, load 1 → code steps 3→2→1 (still one step per DIV cycles), then a single `done`.
  - Repeat, but assert `rst` at `code_cur`=6 → all outputs return to their reset values at that edge.
